// File: rtl/fft_pipe_sequencer_if.sv
// rtl/fft_pipe_sequencer_if.sv - control/status bundle between stream source and FFT sequencer
// Purpose: groups the sequencer's handshake inputs and stage-control outputs.
// Signals:
//   i_start, i_valid, i_flush      : source -> sequencer controls
//   o_coef0_addr, o_coef1_addr     : twiddle ROM addresses (CW bits)
//   o_blq_ctrl, o_stage2_en        : Blq select and stage-2 enable
//   o_enable, o_frame_start        : output-lane qualifiers
//   o_frame_cnt (FCW bits), o_busy : status
// Modports: master drives the i_* controls, slave is the sequencer side.
interface fft_pipe_sequencer_if #(
    parameter int CW  = 5,
    parameter int FCW = 16
);
    logic           i_start;
    logic           i_valid;
    logic           i_flush;
    logic [CW-1:0]  o_coef0_addr;
    logic [CW-1:0]  o_coef1_addr;
    logic           o_blq_ctrl;
    logic           o_stage2_en;
    logic           o_enable;
    logic           o_frame_start;
    logic [FCW-1:0] o_frame_cnt;
    logic           o_busy;

    modport master (
        output i_start, i_valid, i_flush,
        input  o_coef0_addr, o_coef1_addr, o_blq_ctrl, o_stage2_en,
               o_enable, o_frame_start, o_frame_cnt, o_busy
    );

    modport slave (
        input  i_start, i_valid, i_flush,
        output o_coef0_addr, o_coef1_addr, o_blq_ctrl, o_stage2_en,
               o_enable, o_frame_start, o_frame_cnt, o_busy
    );
endinterface

// File: rtl/fft_pipe_sequencer.sv
// rtl/fft_pipe_sequencer.sv - FSM sequencer for the 4-lane radix-2^2 SDF FFT front end
// Purpose: one IDLE/FILL/RUN/DRAIN FSM generating all stage controls, with
//          input stall (i_valid) and a flush/drain sequence.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : fft_pipe_sequencer_if.slave (controls in, stage controls/status out)
module fft_pipe_sequencer #(
    parameter int N     = 128,
    parameter int P     = 4,
    parameter int DEPTH = 16,
    parameter int FCW   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_pipe_sequencer_if.slave   bus
);
    localparam int FRAME = N / P;
    localparam int CW    = $clog2(FRAME);
    localparam int DW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           w_adv;
    logic           w_stage2;
    logic           w_phase_done;
    logic           w_to_idle;
    logic           w_cnt0_wrap;
    logic           w_cnt1_wrap;
    logic           w_blq_wrap;

    logic [DW-1:0]  r_phase_cnt;   // fill count in FILL, drain count in DRAIN
    logic [DW-1:0]  r_blq_cnt;
    logic [CW-1:0]  r_cnt0;
    logic [CW-1:0]  r_cnt1;
    logic           r_blq_ctrl;
    logic           r_enable;
    logic           r_frame_start;
    logic [FCW-1:0] r_frame_cnt;

    assign w_stage2     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_phase_done = (r_phase_cnt == DW'(DEPTH - 1));
    assign w_cnt0_wrap  = (r_cnt0 == CW'(FRAME - 1));
    assign w_cnt1_wrap  = (r_cnt1 == CW'(FRAME - 1));
    assign w_blq_wrap   = (r_blq_cnt == DW'(DEPTH - 1));
    assign w_to_idle    = (r_state != S_IDLE) && (w_next == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_adv  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                w_adv = bus.i_valid;
                // flush outranks fill completion so a flushed fill never emits output
                if (bus.i_flush) begin
                    w_next = S_IDLE;
                end else if (w_adv && w_phase_done) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_adv = bus.i_valid;
                if (bus.i_flush) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_adv = 1'b1;
                if (w_phase_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Cleared on every state change so each FILL and DRAIN starts counting from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase_cnt <= '0;
        end else if (w_next != r_state) begin
            r_phase_cnt <= '0;
        end else if (w_adv && ((r_state == S_FILL) || (r_state == S_DRAIN))) begin
            r_phase_cnt <= r_phase_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt0        <= '0;
            r_cnt1        <= '0;
            r_blq_cnt     <= '0;
            r_blq_ctrl    <= 1'b0;
            r_enable      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_enable      <= w_stage2 & w_adv;
            r_frame_start <= w_stage2 & w_adv & (r_cnt1 == '0);
            // the last drain sample may still complete a frame
            if (w_stage2 && w_adv && w_cnt1_wrap) begin
                r_frame_cnt <= r_frame_cnt + FCW'(1);
            end
            if (w_to_idle) begin
                r_cnt0     <= '0;
                r_cnt1     <= '0;
                r_blq_cnt  <= '0;
                r_blq_ctrl <= 1'b0;
            end else if (w_adv) begin
                r_cnt0 <= w_cnt0_wrap ? '0 : r_cnt0 + CW'(1);
                if (w_stage2) begin
                    r_cnt1    <= w_cnt1_wrap ? '0 : r_cnt1 + CW'(1);
                    r_blq_cnt <= w_blq_wrap ? '0 : r_blq_cnt + DW'(1);
                    if (w_blq_wrap) begin
                        r_blq_ctrl <= ~r_blq_ctrl;
                    end
                end
            end
        end
    end

    assign bus.o_coef0_addr  = r_cnt0;
    assign bus.o_coef1_addr  = r_cnt1;
    assign bus.o_blq_ctrl    = r_blq_ctrl;
    assign bus.o_stage2_en   = w_stage2;
    assign bus.o_enable      = r_enable;
    assign bus.o_frame_start = r_frame_start;
    assign bus.o_frame_cnt   = r_frame_cnt;
    assign bus.o_busy        = (r_state != S_IDLE);
endmodule
